// File: rtl/seg7_scan_mux.sv
// Five-digit multiplexed 7-segment driver with frame-synchronous double buffer.
// Optional leading-zero blanking via `define LEADING_ZERO_BLANK_EN.
module seg7_scan_mux #(
  parameter int          CLK_DIV      = 50000,
  parameter int          BLANK_CYCLES = 16,
  parameter logic [6:0]  ZERO_PAT     = 7'b0111111
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] seg_in4,
  input  logic [6:0] seg_in3,
  input  logic [6:0] seg_in2,
  input  logic [6:0] seg_in1,
  input  logic [6:0] seg_in0,
  output logic [6:0] seg_out,
  output logic [4:0] an_out,
  output logic       frame_done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]   p;
  logic [2:0]      idx;
  logic            pending;
  logic [4:0][6:0] shadow;
  logic [4:0][6:0] active;

  logic       p_wrap;
  logic       frame_edge;
  logic       blank_win;
  logic [4:0] lead;
  logic       digit_off;
  logic [6:0] seg_next;
  logic [4:0] an_next;

  assign p_wrap     = (p == P_LAST);
  assign frame_edge = p_wrap && (idx == 3'd4);
  assign blank_win  = (32'(p) < BLANK_CYCLES);

`ifdef LEADING_ZERO_BLANK_EN
  // A zero is leading only if every more-significant digit is zero too.
  always_comb begin
    lead    = '0;
    lead[4] = (active[4] == ZERO_PAT);
    for (int i = 3; i >= 1; i--) begin
      lead[i] = lead[i+1] && (active[i] == ZERO_PAT);
    end
  end
`else
  assign lead = '0;
`endif

  assign digit_off = blank_win || lead[idx];

  always_comb begin
    seg_next = '0;
    an_next  = 5'b11111;
    if (!digit_off) begin
      seg_next = active[idx];
      an_next  = ~(5'b00001 << idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p   <= '0;
      idx <= '0;
    end else begin
      p <= p_wrap ? '0 : p + 1'b1;
      if (p_wrap) begin
        idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end
    end
  end

  // Active only follows shadow at the frame boundary, so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      active     <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_edge && pending;
      if (frame_edge && pending) begin
        active <= shadow;
      end
      if (load) begin
        shadow  <= {seg_in4, seg_in3, seg_in2, seg_in1, seg_in0};
        pending <= 1'b1;
      end else if (frame_edge) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out <= '0;
      an_out  <= 5'b11111;
    end else begin
      seg_out <= seg_next;
      an_out  <= an_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux at CLK_DIV=8, BLANK_CYCLES=2.
// Edge k is the k-th rising edge after reset release.
module tb_seg7_scan_mux;

  localparam logic [6:0] S0 = 7'b0111111;
  localparam logic [6:0] S1 = 7'b0000110;
  localparam logic [6:0] S2 = 7'b1011011;
  localparam logic [6:0] S3 = 7'b1001111;
  localparam logic [6:0] S4 = 7'b1100110;
  localparam logic [6:0] S5 = 7'b1101101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [6:0] seg_in4 = '0;
  logic [6:0] seg_in3 = '0;
  logic [6:0] seg_in2 = '0;
  logic [6:0] seg_in1 = '0;
  logic [6:0] seg_in0 = '0;
  logic [6:0] seg_out;
  logic [4:0] an_out;
  logic       frame_done;

  int errors = 0;
  int checks = 0;
  int e = 0;

  seg7_scan_mux #(
    .CLK_DIV      (8),
    .BLANK_CYCLES (2),
    .ZERO_PAT     (S0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .seg_in4    (seg_in4),
    .seg_in3    (seg_in3),
    .seg_in2    (seg_in2),
    .seg_in1    (seg_in1),
    .seg_in0    (seg_in0),
    .seg_out    (seg_out),
    .an_out     (an_out),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    e++;
    #1;
  endtask

  task automatic run_to(input int k);
    while (e < k) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic load_at(input int k, input logic [6:0] d4, input logic [6:0] d3,
                         input logic [6:0] d2, input logic [6:0] d1,
                         input logic [6:0] d0);
    run_to(k - 1);
    seg_in4 = d4;
    seg_in3 = d3;
    seg_in2 = d2;
    seg_in1 = d1;
    seg_in0 = d0;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int k,
                            input logic [4:0] an, input logic [6:0] seg);
    run_to(k);
    check({tag, "_an"}, 32'(an_out), 32'(an));
    check({tag, "_seg"}, 32'(seg_out), 32'(seg));
  endtask

  initial begin
    // Reset and first enable
    do_reset();
    check("rst_an", 32'(an_out), 32'h1f);
    check("rst_fd", 32'(frame_done), 32'h0);
    expect_out("e2", 2, 5'b11111, 7'd0);
    expect_out("e3", 3, 5'b11110, 7'd0);
    expect_out("e12", 12, 5'b11101, 7'd0);

    // Basic update: 1,2,3,4,5 on digits 4..0
    do_reset();
    load_at(5, S1, S2, S3, S4, S5);
    expect_out("old_d4", 35, 5'b01111, 7'd0);
    run_to(39);
    check("fd39", 32'(frame_done), 32'h0);
    run_to(40);
    check("fd40", 32'(frame_done), 32'h1);
    run_to(41);
    check("fd41", 32'(frame_done), 32'h0);
    expect_out("b42", 42, 5'b11111, 7'd0);
    expect_out("b43", 43, 5'b11110, S5);
    expect_out("b48", 48, 5'b11110, S5);
    expect_out("b49", 49, 5'b11111, 7'd0);
    expect_out("b51", 51, 5'b11101, S4);
    expect_out("b59", 59, 5'b11011, S3);
    expect_out("b67", 67, 5'b10111, S2);
    expect_out("b75", 75, 5'b01111, S1);
    run_to(80);
    check("fd80_idle", 32'(frame_done), 32'h0);
    expect_out("b83", 83, 5'b11110, S5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an", 32'(an_out), 32'h1f);
    check("async_seg", 32'(seg_out), 32'h0);
    check("async_fd", 32'(frame_done), 32'h0);

    // Load on the boundary edge with nothing pending
    do_reset();
    load_at(40, S5, S4, S3, S2, S1);
    check("lb_fd40", 32'(frame_done), 32'h0);
    expect_out("lb43", 43, 5'b11110, 7'd0);
    run_to(80);
    check("lb_fd80", 32'(frame_done), 32'h1);
    expect_out("lb82", 82, 5'b11111, 7'd0);
    expect_out("lb83", 83, 5'b11110, S1);
    expect_out("lb91", 91, 5'b11101, S2);

    // Multiple loads in one frame: last wins, single pulse
    do_reset();
    load_at(10, S1, S1, S1, S1, S1);
    load_at(20, S0, S2, S4, S1, S3);
    run_to(40);
    check("ml_fd40", 32'(frame_done), 32'h1);
    run_to(41);
    check("ml_fd41", 32'(frame_done), 32'h0);
    expect_out("ml43", 43, 5'b11110, S3);
    expect_out("ml51", 51, 5'b11101, S1);
    expect_out("ml75", 75, 5'b01111, S0);
    run_to(80);
    check("ml_fd80", 32'(frame_done), 32'h0);

`ifdef LEADING_ZERO_BLANK_EN
    do_reset();
    load_at(5, S0, S0, S0, S4, S2);
    expect_out("lz43", 43, 5'b11110, S2);
    expect_out("lz51", 51, 5'b11101, S4);
    expect_out("lz59", 59, 5'b11111, 7'd0);
    expect_out("lz67", 67, 5'b11111, 7'd0);
    expect_out("lz75", 75, 5'b11111, 7'd0);
    load_at(45, S0, S0, S0, S0, S0);
    expect_out("lz0_83", 83, 5'b11110, S0);
    expect_out("lz0_91", 91, 5'b11111, 7'd0);
    load_at(85, S1, S0, S0, S0, S2);
    expect_out("lzi123", 123, 5'b11110, S2);
    expect_out("lzi131", 131, 5'b11101, S0);
    expect_out("lzi147", 147, 5'b10111, S0);
    expect_out("lzi155", 155, 5'b01111, S1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
